hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller for the 5-stage core, sitting upstream of forwarding_unit. It does three things:
- Detects load-use hazards in IF/ID vs. ID/EX and inserts exactly one bubble, so that forwarding_unit can forward the loaded value from MEM/WB (forwardA/B = 2'b11).
- Freezes the whole pipeline while data memory is busy.
- Flushes on taken branches.

It also keeps saturating hazard counters and a memory-timeout watchdog.

## Interface
Parameters:
- CNT_W, 16: width of each performance counter.
- TIMEOUT, 255: maximum consecutive busy cycles before the watchdog trips (≥1).

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- rs1_label_if_id_o  in  5  rs1 of instruction in IF/ID.
- rs2_label_if_id_o  in  5  rs2 of instruction in IF/ID.
- uses_rs2_if_id_i  in  1  IF/ID instruction reads rs2.
- rd_label_id_ex_o  in  5  rd of instruction in ID/EX.
- reg_wb_en_id_ex_o  in  1  ID/EX instruction writes rd.
- is_load_instr_ex_i  in  1  ID/EX instruction is a load.
- branch_taken_ex_i  in  1  single-cycle pulse: taken branch/jump resolved in EX.
- dmem_busy_i  in  1  data memory not ready; the pipeline must hold.
- pc_write_en_o  out  1  PC update enable.
- if_id_write_en_o  out  1  IF/ID register enable.
- id_ex_write_en_o, ex_mem_write_en_o, mem_wb_write_en_o  out  1 each  downstream register enables.
- if_id_flush_o  out  1  load NOP into IF/ID.
- id_ex_flush_o  out  1  load bubble (all control zero) into ID/EX.
- mem_timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o, bubble_cnt_o, flush_cnt_o  out  CNT_W each  saturating counters.

## Operation
- FSM has three states.
  - RUN: normal operation.
  - MEM_WAIT: dmem_busy_i was high in the previous cycle.
  - TIMEOUT: terminal until reset.
- Transitions:
  - RUN→MEM_WAIT when dmem_busy_i=1.
  - MEM_WAIT→RUN when dmem_busy_i=0.
  - MEM_WAIT→TIMEOUT when busy_cnt reaches TIMEOUT while dmem_busy_i=1.
  - TIMEOUT is held until rst_i.
- busy_cnt counts consecutive busy cycles. It clears whenever dmem_busy_i=0.
- Combinational priority, highest first:
  1. Freeze (dmem_busy_i=1, or state TIMEOUT): all five write enables = 0, both flushes = 0.
  2. Flush (branch_taken_ex_i=1 or flush_pending=1): all enables = 1, if_id_flush_o=1, id_ex_flush_o=1.
  3. Load-use: is_load_instr_ex_i & reg_wb_en_id_ex_o & rd≠0 & (rd==rs1 | (uses_rs2 & rd==rs2)). Outputs: pc_write_en_o=0, if_id_write_en_o=0, id_ex_flush_o=1, downstream enables=1.
  4. Otherwise: all enables = 1, flushes = 0.
- flush_pending:
  - Set when branch_taken_ex_i=1 coincides with a freeze.
  - Cleared on the first non-frozen cycle, when the flush is applied.
  - Guarantees a branch pulse is never lost.
- Load-use fires for one cycle only. The bubble removes the load from ID/EX, so there is no self-retrigger.
- rs2 is compared only when uses_rs2_if_id_i=1. x0 never causes a hazard.
- Counters increment on the clock edge and saturate at all-ones:
  - stall_cnt_o: cycles with freeze active.
  - bubble_cnt_o: cycles with load-use bubble active.
  - flush_cnt_o: cycles with flush active.
- mem_timeout_o=1 while in TIMEOUT.

## Timing
- Reset values:
  - State RUN, busy_cnt 0, flush_pending 0, all counters 0, mem_timeout_o 0.
  - Enables follow the combinational rules with RUN state. With idle inputs, all enables = 1 and flushes = 0.
- All hazard outputs are combinational, valid in the same cycle as their inputs (zero latency).
- Counters, flush_pending and FSM change on the next edge.
- Timeout: with dmem_busy_i held high from cycle 0, mem_timeout_o rises after edge TIMEOUT+1.
- rst_i mid-freeze or mid-pending: everything returns to reset values on that edge. The pending flush is discarded.

## Structure
- Shared package core_pkg holds:
  - the hazard-state enum (RUN/MEM_WAIT/TIMEOUT);
  - REG_ADDR_W=5;
  - the x0 constant, also used by forwarding_unit.
- One sub-module, sat_counter (parameter W, ports clk_i/rst_i/inc_i/cnt_o), instantiated three times. Everything else lives in hazard_control_unit.

## Test plan
- Load-use on rs1: ID/EX load rd=5, IF/ID rs1=5 → one cycle with pc_write_en_o=0, if_id_write_en_o=0, id_ex_flush_o=1; bubble_cnt_o=1 after the edge.
- Load with rd=0, or rs2 match with uses_rs2_if_id_i=0 → no stall, all enables 1.
- dmem_busy_i high 3 cycles with a simultaneous branch pulse in cycle 0:
  - all enables 0 for 3 cycles;
  - cycle 3 (busy low) shows if_id_flush_o=id_ex_flush_o=1;
  - stall_cnt_o=3, flush_cnt_o=1.
- Busy + branch + load-use in the same cycle → freeze only. The next cycle applies the flush, not the bubble.
- TIMEOUT=4, dmem_busy_i held high → mem_timeout_o=1 after the 5th edge, then stays high after busy drops. rst_i clears it.
- Force all counters to saturate (CNT_W=2) → each holds at 3.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states and register-address constants.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Architectural zero register; never a true data dependency.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    StRun     = 2'b00,
    StMemWait = 2'b01,
    StTimeout = 2'b10
  } hazard_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: memory freeze, branch flush, load-use bubble,
// saturating event counters and a data-memory watchdog.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_label_if_id_o,
  input  logic [REG_ADDR_W-1:0] rs2_label_if_id_o,
  input  logic                  uses_rs2_if_id_i,
  input  logic [REG_ADDR_W-1:0] rd_label_id_ex_o,
  input  logic                  reg_wb_en_id_ex_o,
  input  logic                  is_load_instr_ex_i,
  input  logic                  branch_taken_ex_i,
  input  logic                  dmem_busy_i,
  output logic                  pc_write_en_o,
  output logic                  if_id_write_en_o,
  output logic                  id_ex_write_en_o,
  output logic                  ex_mem_write_en_o,
  output logic                  mem_wb_write_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  mem_timeout_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      bubble_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  // Wide enough to hold TIMEOUT; the count sticks there once reached.
  localparam int unsigned BusyW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [BusyW-1:0] BusyMax = BusyW'(TIMEOUT);

  hazard_state_e   state_q, state_d;
  logic [BusyW-1:0] busy_cnt_q, busy_cnt_d;
  logic             flush_pending_q, flush_pending_d;

  logic load_use_hit;
  logic freeze_act;
  logic flush_act;
  logic bubble_act;

  // Raw load-use dependency between the IF/ID consumer and the ID/EX load.
  always_comb begin
    load_use_hit = 1'b0;
    if (is_load_instr_ex_i && reg_wb_en_id_ex_o && (rd_label_id_ex_o != REG_X0)) begin
      if (rd_label_id_ex_o == rs1_label_if_id_o) begin
        load_use_hit = 1'b1;
      end
      if (uses_rs2_if_id_i && (rd_label_id_ex_o == rs2_label_if_id_o)) begin
        load_use_hit = 1'b1;
      end
    end
  end

  // Priority resolution: freeze > flush > load-use bubble > normal flow.
  always_comb begin
    freeze_act        = dmem_busy_i || (state_q == StTimeout);
    flush_act         = 1'b0;
    bubble_act        = 1'b0;
    pc_write_en_o     = 1'b1;
    if_id_write_en_o  = 1'b1;
    id_ex_write_en_o  = 1'b1;
    ex_mem_write_en_o = 1'b1;
    mem_wb_write_en_o = 1'b1;
    if_id_flush_o     = 1'b0;
    id_ex_flush_o     = 1'b0;

    if (freeze_act) begin
      pc_write_en_o     = 1'b0;
      if_id_write_en_o  = 1'b0;
      id_ex_write_en_o  = 1'b0;
      ex_mem_write_en_o = 1'b0;
      mem_wb_write_en_o = 1'b0;
    end else if (branch_taken_ex_i || flush_pending_q) begin
      flush_act     = 1'b1;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (load_use_hit) begin
      // Hold PC and IF/ID, drop a bubble into ID/EX; the load moves on to
      // MEM so the dependent instruction sees it via MEM/WB forwarding.
      bubble_act       = 1'b1;
      pc_write_en_o    = 1'b0;
      if_id_write_en_o = 1'b0;
      id_ex_flush_o    = 1'b1;
    end
  end

  // A branch seen while frozen is remembered until it can be applied.
  always_comb begin
    flush_pending_d = flush_pending_q;
    if (freeze_act) begin
      if (branch_taken_ex_i) begin
        flush_pending_d = 1'b1;
      end
    end else begin
      flush_pending_d = 1'b0;
    end
  end

  // Watchdog FSM and consecutive-busy counter.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = '0;
    if (dmem_busy_i) begin
      busy_cnt_d = (busy_cnt_q == BusyMax) ? busy_cnt_q : busy_cnt_q + BusyW'(1);
    end

    unique case (state_q)
      StRun: begin
        if (dmem_busy_i) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (!dmem_busy_i) begin
          state_d = StRun;
        end else if (busy_cnt_q >= BusyMax) begin
          state_d = StTimeout;
        end
      end
      StTimeout: begin
        state_d = StTimeout;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StRun;
      busy_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      busy_cnt_q      <= busy_cnt_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign mem_timeout_o = (state_q == StTimeout);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (freeze_act),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_act),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(
    .W (CNT_W)
  ) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_act),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_hazard_control_unit;

  localparam int unsigned Tmo = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs2, wb_en, is_load, br, busy;

  logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_iff, a_idf, a_to;
  logic [15:0] a_stall, a_bub, a_fl;
  logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_iff, b_idf, b_to;
  logic [1:0]  b_stall, b_bub, b_fl;

  int checks = 0;
  int errors = 0;

  // Model state: plain counts and flags.
  int m_run, m_stall, m_bub, m_fl;
  bit m_to, m_pend;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(16), .TIMEOUT(Tmo)) u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .rs1_label_if_id_o(rs1), .rs2_label_if_id_o(rs2), .uses_rs2_if_id_i(uses_rs2),
    .rd_label_id_ex_o(rd), .reg_wb_en_id_ex_o(wb_en), .is_load_instr_ex_i(is_load),
    .branch_taken_ex_i(br), .dmem_busy_i(busy),
    .pc_write_en_o(a_pc), .if_id_write_en_o(a_ifid), .id_ex_write_en_o(a_idex),
    .ex_mem_write_en_o(a_exmem), .mem_wb_write_en_o(a_memwb),
    .if_id_flush_o(a_iff), .id_ex_flush_o(a_idf), .mem_timeout_o(a_to),
    .stall_cnt_o(a_stall), .bubble_cnt_o(a_bub), .flush_cnt_o(a_fl)
  );

  hazard_control_unit #(.CNT_W(2), .TIMEOUT(Tmo)) u_sat (
    .clk_i(clk), .rst_i(rst_i),
    .rs1_label_if_id_o(rs1), .rs2_label_if_id_o(rs2), .uses_rs2_if_id_i(uses_rs2),
    .rd_label_id_ex_o(rd), .reg_wb_en_id_ex_o(wb_en), .is_load_instr_ex_i(is_load),
    .branch_taken_ex_i(br), .dmem_busy_i(busy),
    .pc_write_en_o(b_pc), .if_id_write_en_o(b_ifid), .id_ex_write_en_o(b_idex),
    .ex_mem_write_en_o(b_exmem), .mem_wb_write_en_o(b_memwb),
    .if_id_flush_o(b_iff), .id_ex_flush_o(b_idf), .mem_timeout_o(b_to),
    .stall_cnt_o(b_stall), .bubble_cnt_o(b_bub), .flush_cnt_o(b_fl)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Model's view of the current cycle: what kind of cycle is this?
  task automatic classify(output bit frz, output bit fl, output bit bub);
    bit dep;
    dep = is_load && wb_en && (rd != 0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    frz = busy || m_to;
    fl  = !frz && (br || m_pend);
    bub = !frz && !fl && dep;
  endtask

  task automatic cmp_all();
    bit frz, fl, bub;
    logic [4:0] en;
    logic [1:0] fls;
    classify(frz, fl, bub);
    en  = {!frz && !bub, !frz && !bub, !frz, !frz, !frz};
    fls = {fl, fl || bub};
    check("en_a", {a_pc, a_ifid, a_idex, a_exmem, a_memwb}, en);
    check("flush_a", {a_iff, a_idf}, fls);
    check("en_b", {b_pc, b_ifid, b_idex, b_exmem, b_memwb}, en);
    check("flush_b", {b_iff, b_idf}, fls);
    check("timeout_a", a_to, m_to);
    check("timeout_b", b_to, m_to);
    check("stall_a", a_stall, sat(m_stall, 65535));
    check("bubble_a", a_bub, sat(m_bub, 65535));
    check("flushcnt_a", a_fl, sat(m_fl, 65535));
    check("stall_b", b_stall, sat(m_stall, 3));
    check("bubble_b", b_bub, sat(m_bub, 3));
    check("flushcnt_b", b_fl, sat(m_fl, 3));
  endtask

  task automatic model_reset();
    m_run = 0; m_stall = 0; m_bub = 0; m_fl = 0; m_to = 0; m_pend = 0;
  endtask

  task automatic model_edge();
    bit frz, fl, bub;
    if (rst_i) begin
      model_reset();
    end else begin
      classify(frz, fl, bub);
      m_stall += frz;
      m_fl    += fl;
      m_bub   += bub;
      if (frz && br) m_pend = 1;
      else if (!frz) m_pend = 0;
      // Trip on the (Tmo+1)-th consecutive busy cycle.
      m_run = busy ? m_run + 1 : 0;
      if (m_run >= Tmo + 1) m_to = 1;
    end
  endtask

  // One cycle: inputs already driven; compare at negedge, advance at posedge.
  task automatic tick();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 0; rs2 = 0; rd = 0; uses_rs2 = 0; wb_en = 0; is_load = 0; br = 0; busy = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_i = 0;
  endtask

  initial begin
    do_reset();

    // Reset state with idle inputs.
    check("rst_en", {a_pc, a_ifid, a_idex, a_exmem, a_memwb}, 5'b11111);
    check("rst_flush", {a_iff, a_idf}, 2'b00);
    check("rst_cnt", {a_stall, a_bub, a_fl}, 48'd0);
    check("rst_to", a_to, 1'b0);
    tick();

    // Load-use on rs1.
    is_load = 1; wb_en = 1; rd = 5; rs1 = 5; #1;
    check("lu_en", {a_pc, a_ifid, a_idex, a_exmem, a_memwb}, 5'b00111);
    check("lu_flush", {a_iff, a_idf}, 2'b01);
    tick();
    check("lu_bubcnt", a_bub, 16'd1);

    // x0 destination never stalls.
    rd = 0; rs1 = 0; #1;
    check("x0_en", {a_pc, a_ifid, a_idex, a_exmem, a_memwb}, 5'b11111);
    tick();
    // rs2 match ignored when rs2 is not read.
    rd = 7; rs1 = 3; rs2 = 7; uses_rs2 = 0; #1;
    check("rs2off_en", {a_pc, a_ifid, a_idex, a_exmem, a_memwb}, 5'b11111);
    tick();
    uses_rs2 = 1; #1;
    check("rs2on_en", {a_pc, a_ifid}, 2'b00);
    tick();

    // Three busy cycles with a branch in the first; flush lands afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      busy = 1; br = (i == 0); #1;
      check("frz_en", {a_pc, a_ifid, a_idex, a_exmem, a_memwb}, 5'b00000);
      tick();
    end
    busy = 0; br = 0; #1;
    check("pend_flush", {a_iff, a_idf}, 2'b11);
    tick();
    check("pend_stall", a_stall, 16'd3);
    check("pend_flcnt", a_fl, 16'd1);

    // Freeze beats branch and load-use; next cycle flushes rather than bubbles.
    do_reset();
    busy = 1; br = 1; is_load = 1; wb_en = 1; rd = 9; rs1 = 9; #1;
    check("mix_frz", {a_pc, a_ifid, a_idex, a_iff, a_idf}, 5'b00000);
    tick();
    busy = 0; br = 0; #1;
    check("mix_flush", {a_pc, a_ifid, a_iff, a_idf}, 4'b1111);
    tick();
    check("mix_cnts", {a_bub, a_fl}, {16'd0, 16'd1});

    // Watchdog: busy held from the first cycle.
    do_reset();
    busy = 1;
    repeat (4) tick();
    check("to_early", a_to, 1'b0);
    tick();
    check("to_set", a_to, 1'b1);
    busy = 0;
    tick();
    check("to_sticky", a_to, 1'b1);
    check("sat_stall", b_stall, 2'd3);
    rst_i = 1;
    tick();
    rst_i = 0;
    check("to_clear", a_to, 1'b0);

    // Saturate flush and bubble counters on the narrow instance.
    br = 1;
    repeat (5) tick();
    br = 0; is_load = 1; wb_en = 1; rd = 4; rs1 = 4;
    repeat (5) tick();
    check("sat_fl", b_fl, 2'd3);
    check("sat_bub", b_bub, 2'd3);
    check("wide_fl", a_fl, 16'd5);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      rst_i    = ($urandom_range(0, 199) == 0);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      rd       = 5'($urandom_range(0, 7));
      uses_rs2 = 1'($urandom_range(0, 1));
      wb_en    = ($urandom_range(0, 3) != 0);
      is_load  = ($urandom_range(0, 2) == 0);
      br       = ($urandom_range(0, 6) == 0);
      busy     = (n % 500 > 480) ? 1'b1 : ($urandom_range(0, 3) == 0);
      tick();
    end
    rst_i = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
